// File: rtl/lap_stopwatch.sv
// BCD stopwatch with run/stop, lap freeze and clear, feeding a seven-segment controller.
// Digit SEXA_DIGIT counts 0..5 for mm:ss-style wrap; overflow is sticky until cleared.
module lap_stopwatch #(
  parameter int NUM_DIGITS  = 4,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int SEXA_DIGIT  = 3,
  parameter int DP_POSITION = 2,
  parameter int WRAP_ON_OVF = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    lap,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_point,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow
);

  localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  state_t                  state;
  logic [4*NUM_DIGITS-1:0] count;
  logic [4*NUM_DIGITS-1:0] lap_reg;
  logic [4*NUM_DIGITS-1:0] count_inc;
  logic [4*NUM_DIGITS-1:0] count_max;
  logic [PW-1:0]           presc;
  logic                    counting;
  logic                    tick;
  logic                    at_max;
  logic                    carry;
  logic [3:0]              dmax;
  logic [3:0]              dcur;

  // Ripple-carry BCD increment; each digit wraps at its own maximum.
  always_comb begin
    count_inc = '0;
    count_max = '0;
    carry     = 1'b1;
    dmax      = 4'd9;
    dcur      = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dmax = (int'(i) == SEXA_DIGIT) ? 4'd5 : 4'd9;
      dcur = count[4*i +: 4];
      count_max[4*i +: 4] = dmax;
      if (carry) begin
        if (dcur == dmax) begin
          count_inc[4*i +: 4] = '0;
        end else begin
          count_inc[4*i +: 4] = dcur + 4'd1;
          carry = 1'b0;
        end
      end else begin
        count_inc[4*i +: 4] = dcur;
      end
    end
  end

  assign at_max   = (count == count_max);
  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      lap_reg    <= '0;
      presc      <= '0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (counting) begin
        presc <= tick ? '0 : presc + 1'b1;
      end
      if (tick) begin
        if (at_max) begin
          overflow <= 1'b1;
          if (WRAP_ON_OVF != 0) begin
            count <= '0;
          end
        end else begin
          count <= count_inc;
        end
      end
      // Pulse priority: start_stop, then lap, then clear.
      case (state)
        IDLE: begin
          if (start_stop) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_stop) begin
            state   <= STOP;
            running <= 1'b0;
          end else if (lap) begin
            state      <= LAP;
            lap_reg    <= count;
            lap_active <= 1'b1;
          end
        end
        LAP: begin
          if (start_stop) begin
            state      <= STOP;
            running    <= 1'b0;
            lap_active <= 1'b0;
          end else if (lap) begin
            lap_reg <= count;
          end else if (clear) begin
            state      <= RUN;
            lap_active <= 1'b0;
          end
        end
        STOP: begin
          if (start_stop) begin
            state   <= RUN;
            running <= 1'b1;
          end else if (clear) begin
            state    <= IDLE;
            count    <= '0;
            presc    <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digits      = lap_active ? lap_reg : count;
  assign digit_point = NUM_DIGITS'(1) << DP_POSITION;

endmodule
